// File: rtl/stage2_decode_if.sv
// Decode/execute bundle carried from stage 2 to stage 3.
interface stage2_decode_if #(
  parameter int DATA_W = 8
);
  logic              valid_out;
  logic [3:0]        op_out;
  logic [3:0]        rd_out;
  logic              wr_out;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [7:0]        address_out;
  logic [7:0]        pc_out;
  logic [1:0]        count_out;

  modport master (
    output valid_out, op_out, rd_out, wr_out,
    output a_out, b_out, address_out, pc_out, count_out
  );

  modport slave (
    input valid_out, op_out, rd_out, wr_out,
    input a_out, b_out, address_out, pc_out, count_out
  );
endinterface

// File: rtl/stage2_decode.sv
// Stage 2 of the 8-bit-PC CPU: next-PC generation, register file with
// write-back bypass, load-use and branch hazard detection, and the
// registered decode/execute bundle for stage 3.
module stage2_decode #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [7:0]        pc_in,
  input  logic [15:0]       instruction,
  input  logic [3:0]        D,
  input  logic [7:0]        address,
  input  logic [1:0]        count,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mem_wr,
  input  logic [3:0]        mem_rd,
  output logic [7:0]        Next_pc,
  output logic              stall,
  stage2_decode_if.master   dx
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_LOADI = 4'd5,
    OP_LOAD  = 4'd6,
    OP_STORE = 4'd7,
    OP_JMP   = 4'd8,
    OP_BEQZ  = 4'd9
  } opcode_e;

  logic [DATA_W-1:0] rf [16];

  opcode_e           op;
  logic [3:0]        s1;
  logic [3:0]        s2;
  logic              is_alu;
  logic              reads_d;
  logic              writes_reg;
  logic [DATA_W-1:0] s1_val;
  logic [DATA_W-1:0] s2_val;
  logic [DATA_W-1:0] d_val;
  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] b_nxt;
  logic              load_use;
  logic              branch_stall;
  logic              unused_bits;

  // D arrives as its own port; the copy inside the instruction word is redundant.
  assign unused_bits = ^instruction[11:8];
  assign s1 = instruction[7:4];
  assign s2 = instruction[3:0];

  // Opcode decode; 10..15 collapse onto NOP.
  always_comb begin
    op         = OP_NOP;
    is_alu     = 1'b0;
    reads_d    = 1'b0;
    writes_reg = 1'b0;
    case (instruction[15:12])
      4'd1: op = OP_ADD;
      4'd2: op = OP_SUB;
      4'd3: op = OP_AND;
      4'd4: op = OP_OR;
      4'd5: op = OP_LOADI;
      4'd6: op = OP_LOAD;
      4'd7: op = OP_STORE;
      4'd8: op = OP_JMP;
      4'd9: op = OP_BEQZ;
      default: op = OP_NOP;
    endcase
    is_alu     = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    reads_d    = (op == OP_STORE) || (op == OP_BEQZ);
    writes_reg = is_alu || (op == OP_LOADI) || (op == OP_LOAD);
  end

  // Register reads with write-back bypass.
  always_comb begin
    s1_val = (wb_en && (wb_addr == s1)) ? wb_data : rf[s1];
    s2_val = (wb_en && (wb_addr == s2)) ? wb_data : rf[s2];
    d_val  = (wb_en && (wb_addr == D))  ? wb_data : rf[D];
  end

  // Operand selection; operands an opcode does not use stay zero.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    if (is_alu) begin
      a_nxt = s1_val;
      b_nxt = s2_val;
    end else if (reads_d) begin
      a_nxt = d_val;
    end else if (op == OP_LOADI) begin
      b_nxt = DATA_W'(address);
    end
  end

  // Hazard detection against the registered bundle and the stage-3 writer.
  always_comb begin
    load_use = dx.valid_out && (dx.op_out == OP_LOAD) &&
               ((is_alu && ((s1 == dx.rd_out) || (s2 == dx.rd_out))) ||
                (reads_d && (D == dx.rd_out)));
    branch_stall = (op == OP_BEQZ) &&
                   ((dx.wr_out && (dx.rd_out == D)) || (mem_wr && (mem_rd == D)));
    stall = load_use || branch_stall;
  end

  // Next PC: hold on stall, otherwise resolve jumps/branches here.
  always_comb begin
    Next_pc = pc_in + 8'd1;
    if (stall) begin
      Next_pc = pc_in;
    end else if (op == OP_JMP) begin
      Next_pc = address;
    end else if ((op == OP_BEQZ) && (d_val == '0)) begin
      Next_pc = address;
    end
  end

  // Register file; write-back lands at the same edge its value is bypassed.
  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      for (int unsigned i = 0; i < 16; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Decode/execute bundle: bubble on stall, decoded instruction otherwise.
  always_ff @(posedge clk or negedge en) begin
    if (!en) begin
      dx.valid_out   <= 1'b0;
      dx.op_out      <= '0;
      dx.rd_out      <= '0;
      dx.wr_out      <= 1'b0;
      dx.a_out       <= '0;
      dx.b_out       <= '0;
      dx.address_out <= '0;
      dx.pc_out      <= '0;
      dx.count_out   <= '0;
    end else if (stall) begin
      dx.valid_out   <= 1'b0;
      dx.op_out      <= '0;
      dx.rd_out      <= '0;
      dx.wr_out      <= 1'b0;
      dx.a_out       <= '0;
      dx.b_out       <= '0;
      dx.address_out <= '0;
      dx.pc_out      <= '0;
      dx.count_out   <= '0;
    end else begin
      dx.valid_out   <= 1'b1;
      dx.op_out      <= op;
      dx.rd_out      <= D;
      dx.wr_out      <= writes_reg;
      dx.a_out       <= a_nxt;
      dx.b_out       <= b_nxt;
      dx.address_out <= address;
      dx.pc_out      <= pc_in;
      dx.count_out   <= count;
    end
  end

endmodule

// File: doc/stage2_decode.md
# stage2_decode

Second pipeline stage of the 8-bit-PC, 16-bit-instruction CPU. Consumes the fetch outputs (PC, instruction, destination field, address field, count tag), generates the `Next_pc` fed back to fetch, reads a 16-entry register file with write-back bypass, and detects hazards. Produces a registered decode/execute bundle for stage 3.

## Interface
Parameters:
- `DATA_W`, 8, register-file and operand width.

Ports:
- `clk`  in  1  rising-edge clock.
- `en`  in  1  reset, asynchronous, active-low.
- `pc_in`  in  8  PC of the instruction currently presented by fetch.
- `instruction`  in  16  fetched word: [15:12] opcode, [11:8] D, [7:4] S1, [3:0] S2, [7:0] address/imm.
- `D`  in  4  destination field from fetch (equals instruction[11:8]).
- `address`  in  8  address/immediate field from fetch (equals instruction[7:0]).
- `count`  in  2  tag from fetch, passed through.
- `wb_en`, `wb_addr`, `wb_data`  in  1/4/DATA_W  write-back port from the last stage.
- `mem_wr`, `mem_rd`  in  1/4  the stage-3 register holds a pending register write to `mem_rd`.
- `Next_pc`  out  8  combinational next PC for fetch.
- `stall`  out  1  combinational; high while the current instruction is held.
- `valid_out`, `op_out`, `rd_out`, `wr_out`  out  1/4/4/1  registered bundle: valid, opcode, destination, writes-register flag.
- `a_out`, `b_out`  out  DATA_W each  registered operands.
- `address_out`, `pc_out`, `count_out`  out  8/8/2  registered pass-through fields.

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR (R[D] = R[S1] op R[S2]); 5 LOADI (R[D] = imm); 6 LOAD (R[D] = mem[address]); 7 STORE (mem[address] = R[D]); 8 JMP; 9 BEQZ (branch to address if R[D] == 0); 10–15 decode as NOP.
- `wr_out` = 1 for opcodes 1–6 only.
- Operands:
  - ALU ops: `a_out` = R[S1], `b_out` = R[S2].
  - STORE and BEQZ: `a_out` = R[D].
  - LOADI: `b_out` = zero-extended imm.
  - All unused operand outputs are 0.
- Register file: 16 x DATA_W, written at posedge when `wb_en`. Reads are combinational with bypass: if `wb_en` and `wb_addr` matches the read index, return `wb_data`.
- Load-use stall: the registered bundle is a valid LOAD, and the current instruction reads its `rd_out`. Reads are S1/S2 for opcodes 1–4 and D for 7 and 9.
- Branch stall: the current instruction is BEQZ, and either the registered bundle has `wr_out` with `rd_out == D`, or `mem_wr` with `mem_rd == D`.
- `stall` = load-use OR branch stall.
- `Next_pc` priority:
  - `stall` → `pc_in` (fetch re-presents the same instruction).
  - JMP → `address`.
  - BEQZ with bypassed R[D] == 0 → `address`.
  - Otherwise `pc_in + 1`, 8-bit wrap (0xFF → 0x00).
- On `stall`: the bundle loads a bubble (`valid_out` = 0, `op_out` = 0, `wr_out` = 0, other fields 0). Otherwise it loads the decoded instruction with `valid_out` = 1.
- JMP and BEQZ enter the bundle with `wr_out` = 0. They are resolved here, so no fetch flush is needed.

## Timing
- Reset (`en` low, asynchronous): every registered output is 0, and all 16 registers are 0. `Next_pc` and `stall` remain combinational functions of their inputs.
- Decode latency is 1 cycle: inputs sampled at posedge N appear on the bundle after posedge N.
- Write-back and decode of the same register in the same cycle: the new value is used (bypass). The file updates at that same edge.
- A load-use stall lasts exactly 1 cycle, because the next bundle is a bubble.
- A branch stall lasts until no pending writer matches: at most 2 cycles behind a single ALU writer.
- Deasserting `en` mid-stall clears the bundle and the registers immediately. After release, the first edge decodes whatever fetch presents.

## Test plan
- Reset, then release with `pc_in` = 0x00 and instruction 0x5307 (LOADI R3, 7) → `Next_pc` = 0x01; after the edge `valid_out` = 1, `op_out` = 5, `rd_out` = 3, `b_out` = 7, `wr_out` = 1.
- Write-back bypass: `wb_en` = 1, `wb_addr` = 2, `wb_data` = 0x2A in the same cycle as ADD R1, R2, R0 (0x1120) → `a_out` = 0x2A; R2 reads 0x2A afterwards.
- Load-use: LOAD R4 (0x6410), then ADD R5, R4, R4 (0x1544) → `stall` = 1 for one cycle, `Next_pc` = `pc_in`, one bubble, then ADD issues.
- JMP 0x80 (0x8080) at `pc_in` 0x10 → `Next_pc` = 0x80 with no stall. With `pc_in` = 0xFF and a NOP → `Next_pc` = 0x00.
- BEQZ R6 (0x9640) with R6 = 0 and no pending writer → `Next_pc` = 0x40. With `mem_wr` = 1 and `mem_rd` = 6 → `stall` held until `mem_wr` drops.
- Pull `en` low between edges during a stall → all bundle outputs 0 immediately. Registers read back 0 after release.
